// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter with a FIFO, configurable frame format and CTS flow control.
// Characters are sent LSB first, and queued frames follow each other with no idle gap.
module uart_tx_buffered #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          cts_n_in,
    output logic                          busy_out,
    output logic                          tx_wire_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int CW     = $clog2(PERIOD);
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_cts_meta;
    logic                   r_cts_sync;
    logic [CW-1:0]          r_baud;
    logic [3:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_busy;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_tick;
    logic                   w_can_start;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_line;
    logic [DATA_BITS-1:0]   w_head;

    assign ready_out      = r_count < (AW+1)'(FIFO_DEPTH);
    assign fifo_count_out = r_count;
    assign tx_wire_out    = r_tx;
    assign busy_out       = r_busy;

    assign w_push      = valid_in && ready_out;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_tick      = r_baud == CW'(PERIOD - 1);
    assign w_can_start = (r_count != '0) && !r_cts_sync;
    assign w_last_data = r_bit_idx == 4'(DATA_BITS - 1);
    assign w_last_stop = r_bit_idx == 4'(STOP_BITS - 1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= cts_n_in;
            r_cts_sync <= r_cts_meta;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A stop-bit end with work queued goes straight to START: no idle bit.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_can_start) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && w_last_data) begin
                    w_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && w_last_stop) begin
                    if (w_can_start) begin
                        w_pop  = 1'b1;
                        w_next = S_START;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_line = 1'b1;
        unique case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
            S_PARITY: w_line = r_par;
            default:  w_line = 1'b1;
        endcase
    end

    // Line and busy are registered together so they change on the same edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_busy <= r_state != S_IDLE;
            if (r_state == S_IDLE || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end
            if (w_next != r_state) begin
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end
            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
            end else if (r_state == S_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule
